// File: rtl/hnf_pocq_alloc_if.sv
// ---------------------------------------------------------------------------
// hnf_pocq_alloc_pkg / hnf_pocq_alloc_if
//
// Purpose : Request flit type and the bundled port interface of the HNF
//           POCQ allocator.
//
// Interface signals (direction given for the allocator, modport slave):
//   req_in        in   head flit of the RXREQ position queue
//   req_in_valid  in   head entry present
//   req_in_ready  out  pop strobe, high in the cycle the head is accepted
//   alloc_req     out  registered accepted flit
//   alloc_idx     out  POCQ slot allocated to alloc_req
//   alloc_valid   out  alloc_req/alloc_idx valid
//   alloc_ready   in   pipeline consumes alloc_*
//   retire_valid  in   retire one slot
//   retire_idx    in   slot to retire
//   pocq_count    out  occupied slot count
//   pocq_full     out  all slots occupied
//   retire_err    out  sticky: retire of an unoccupied slot was seen
//   hazard_stall  out  head blocked only by a same-line hazard
//                      (present only when HNF_POCQ_HAZARD_EN is defined)
//
// modport master is the environment side (queue + pipeline), slave is the
// allocator.
// ---------------------------------------------------------------------------
package hnf_pocq_alloc_pkg;
  typedef struct packed {
    logic [3:0]  QoS;
    logic [6:0]  TgtID;
    logic [6:0]  SrcID;
    logic [7:0]  TxnID;
    logic [5:0]  Opcode;
    logic [2:0]  Size;
    logic [47:0] Addr;
  } reqflit_t;
endpackage

interface hnf_pocq_alloc_if #(
  parameter int POCQ_DEPTH = 16
) ();
  import hnf_pocq_alloc_pkg::*;

  localparam int IDX_W = $clog2(POCQ_DEPTH);

  reqflit_t         req_in;
  logic             req_in_valid;
  logic             req_in_ready;
  reqflit_t         alloc_req;
  logic [IDX_W-1:0] alloc_idx;
  logic             alloc_valid;
  logic             alloc_ready;
  logic             retire_valid;
  logic [IDX_W-1:0] retire_idx;
  logic [IDX_W:0]   pocq_count;
  logic             pocq_full;
  logic             retire_err;
`ifdef HNF_POCQ_HAZARD_EN
  logic             hazard_stall;
`endif

  modport master (
    output req_in, req_in_valid, alloc_ready, retire_valid, retire_idx,
    input  req_in_ready, alloc_req, alloc_idx, alloc_valid,
           pocq_count, pocq_full, retire_err
`ifdef HNF_POCQ_HAZARD_EN
    , input hazard_stall
`endif
  );

  modport slave (
    input  req_in, req_in_valid, alloc_ready, retire_valid, retire_idx,
    output req_in_ready, alloc_req, alloc_idx, alloc_valid,
           pocq_count, pocq_full, retire_err
`ifdef HNF_POCQ_HAZARD_EN
    , output hazard_stall
`endif
  );
endinterface

// File: rtl/hnf_pocq_alloc.sv
// ---------------------------------------------------------------------------
// hnf_pocq_alloc
//
// Purpose : Pops the head request of the RXREQ position queue, allocates it
//           the lowest free Point-of-Coherence Queue slot and presents the
//           flit plus slot index through a registered valid/ready stage.
//           Slots stay occupied until the pipeline retires them by index.
//
// Ports   :
//   clock  single clock
//   reset  synchronous, active-low reset
//   bus    hnf_pocq_alloc_if.slave (request input, allocation output,
//          retire input, occupancy/status outputs)
//
// Parameters:
//   POCQ_DEPTH  number of slots (power of two, 2..64)
//   LINE_LSB    lowest Addr bit of the cache-line address
//
// Build option: HNF_POCQ_HAZARD_EN
//   defined   : the head is held while any occupied slot holds the same
//               cache line; hazard_stall reports that condition.
//   undefined : no line storage, no hazard check, no hazard_stall port.
// ---------------------------------------------------------------------------
module hnf_pocq_alloc
  import hnf_pocq_alloc_pkg::*;
#(
  parameter int POCQ_DEPTH = 16,
  parameter int LINE_LSB   = 6
) (
  input logic             clock,
  input logic             reset,
  hnf_pocq_alloc_if.slave bus
);
  localparam int             IDX_W     = $clog2(POCQ_DEPTH);
  localparam logic [IDX_W:0] DEPTH_CNT = (IDX_W + 1)'(POCQ_DEPTH);

  generate
    if (POCQ_DEPTH < 2 || POCQ_DEPTH > 64 || (POCQ_DEPTH & (POCQ_DEPTH - 1)) != 0 ||
        LINE_LSB < 1 || LINE_LSB > 47) begin : g_bad_param
      $error("hnf_pocq_alloc: unsupported POCQ_DEPTH or LINE_LSB");
    end
  endgenerate

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } out_state_t;

  out_state_t            state_reg, state_next;
  logic [POCQ_DEPTH-1:0] slot_vld_reg, slot_vld_next;
  logic [IDX_W:0]        count_reg, count_next;
  logic                  retire_err_reg, retire_err_next;
  reqflit_t              alloc_req_reg;
  logic [IDX_W-1:0]      alloc_idx_reg;

  logic                  free_any;
  logic [IDX_W-1:0]      free_idx;
  logic                  hazard;
  logic                  out_open;
  logic                  accept;
  logic                  retire_hit;

  // Free-slot search runs on registered occupancy only, so a slot being
  // retired this cycle is never handed out in the same cycle.
  assign free_any = ~&slot_vld_reg;

  always_comb begin
    free_idx = '0;
    for (int i = POCQ_DEPTH - 1; i >= 0; i--) begin
      if (!slot_vld_reg[i]) free_idx = IDX_W'(i);
    end
  end

  // Output register can take a new flit when empty or being drained now.
  assign out_open   = (state_reg == EMPTY) | bus.alloc_ready;
  assign accept     = bus.req_in_valid & reset & free_any & ~hazard & out_open;
  assign retire_hit = bus.retire_valid & slot_vld_reg[bus.retire_idx];

`ifdef HNF_POCQ_HAZARD_EN
  localparam int LINE_W = 48 - LINE_LSB;

  logic [LINE_W-1:0]     slot_line_reg [POCQ_DEPTH];
  logic [LINE_W-1:0]     req_line;
  logic [POCQ_DEPTH-1:0] line_hit;

  assign req_line = bus.req_in.Addr[47:LINE_LSB];

  generate
    for (genvar gi = 0; gi < POCQ_DEPTH; gi++) begin : g_line_hit
      assign line_hit[gi] = slot_vld_reg[gi] & (slot_line_reg[gi] == req_line);
    end
  endgenerate

  assign hazard = |line_hit;

  // Line tags are qualified by slot_vld, so they need no reset.
  always_ff @(posedge clock) begin
    if (accept) slot_line_reg[free_idx] <= req_line;
  end

  assign bus.hazard_stall = bus.req_in_valid & free_any & hazard & out_open;
`else
  assign hazard = 1'b0;
`endif

  // Slot occupancy, count and error flag. Retire and accept may coincide;
  // they always touch different slots because free_idx is never occupied.
  always_comb begin
    slot_vld_next   = slot_vld_reg;
    retire_err_next = retire_err_reg;
    if (retire_hit) begin
      slot_vld_next[bus.retire_idx] = 1'b0;
    end else if (bus.retire_valid) begin
      retire_err_next = 1'b1;
    end
    if (accept) slot_vld_next[free_idx] = 1'b1;
    count_next = count_reg + {{IDX_W{1'b0}}, accept} - {{IDX_W{1'b0}}, retire_hit};
  end

  // Output stage FSM: state register
  always_ff @(posedge clock) begin
    if (!reset) state_reg <= EMPTY;
    else        state_reg <= state_next;
  end

  // Output stage FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY:   if (accept) state_next = HOLD;
      HOLD:    if (bus.alloc_ready && !accept) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  // Output stage FSM: outputs
  assign bus.alloc_valid = (state_reg == HOLD);

  always_ff @(posedge clock) begin
    if (!reset) begin
      slot_vld_reg   <= '0;
      count_reg      <= '0;
      retire_err_reg <= 1'b0;
      alloc_req_reg  <= '0;
      alloc_idx_reg  <= '0;
    end else begin
      slot_vld_reg   <= slot_vld_next;
      count_reg      <= count_next;
      retire_err_reg <= retire_err_next;
      // Loaded only on accept, so the payload holds steady under backpressure.
      if (accept) begin
        alloc_req_reg <= bus.req_in;
        alloc_idx_reg <= free_idx;
      end
    end
  end

  assign bus.req_in_ready = accept;
  assign bus.alloc_req    = alloc_req_reg;
  assign bus.alloc_idx    = alloc_idx_reg;
  assign bus.pocq_count   = count_reg;
  assign bus.pocq_full    = reset & (count_reg == DEPTH_CNT);
  assign bus.retire_err   = retire_err_reg;
endmodule

// File: tb/tb_hnf_pocq_alloc.sv
module tb_hnf_pocq_alloc;
  import hnf_pocq_alloc_pkg::*;

  localparam int D = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  hnf_pocq_alloc_if #(.POCQ_DEPTH(D)) bus ();

  hnf_pocq_alloc #(.POCQ_DEPTH(D), .LINE_LSB(6)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_known = 0;
  bit          m_occ  [D];
  logic [41:0] m_line [D];
  int          m_cnt = 0;
  bit          m_err = 0;
  bit          m_ov  = 0;
  reqflit_t    m_req = '0;
  int          m_idx = 0;
  bit          pop_now = 0;

  always @(negedge clock) begin : cmp
    bit free_any, haz, rdy, stall;
    int f, ri;
    free_any = 0; haz = 0; f = 0;
    for (int i = D - 1; i >= 0; i--) if (!m_occ[i]) begin free_any = 1; f = i; end
`ifdef HNF_POCQ_HAZARD_EN
    for (int i = 0; i < D; i++)
      if (m_occ[i] && m_line[i] == bus.req_in.Addr[47:6]) haz = 1;
`endif
    rdy   = bus.req_in_valid && reset && free_any && !haz && (!m_ov || bus.alloc_ready);
    stall = bus.req_in_valid && free_any && haz && (!m_ov || bus.alloc_ready);
    if (m_known) begin
      chk("req_in_ready", bus.req_in_ready, rdy);
      chk("alloc_valid", bus.alloc_valid, m_ov);
      if (m_ov) begin
        chk("alloc_req", bus.alloc_req, m_req);
        chk("alloc_idx", bus.alloc_idx, m_idx);
      end
      chk("pocq_count", bus.pocq_count, m_cnt);
      chk("pocq_full", bus.pocq_full, reset && m_cnt == D);
      chk("retire_err", bus.retire_err, m_err);
`ifdef HNF_POCQ_HAZARD_EN
      chk("hazard_stall", bus.hazard_stall, stall);
`endif
    end
    pop_now = rdy;
    if (!reset) begin
      for (int i = 0; i < D; i++) m_occ[i] = 0;
      m_cnt = 0; m_err = 0; m_ov = 0; m_req = '0; m_idx = 0;
      m_known = 1;
    end else begin
      ri = int'(bus.retire_idx);
      if (bus.retire_valid) begin
        if (m_occ[ri]) begin m_occ[ri] = 0; m_cnt--; end
        else m_err = 1;
      end
      if (rdy) begin
        m_occ[f] = 1; m_line[f] = bus.req_in.Addr[47:6]; m_cnt++;
        m_ov = 1; m_req = bus.req_in; m_idx = f;
      end else if (bus.alloc_ready) begin
        m_ov = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  reqflit_t pq[$];

  function automatic reqflit_t mk(logic [47:0] a);
    logic [95:0] t;
    reqflit_t    r;
    t = {$urandom, $urandom, $urandom};
    r = reqflit_t'(t[$bits(reqflit_t)-1:0]);
    r.Addr = a;
    return r;
  endfunction

  task automatic drive_head();
    bus.req_in_valid = (pq.size() != 0);
    bus.req_in       = (pq.size() != 0) ? pq[0] : '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (pop_now) void'(pq.pop_front());
    drive_head();
    #1;
  endtask

  task automatic retire_one(int idx);
    bus.retire_valid = 1'b1;
    bus.retire_idx   = 4'(idx);
    tick();
    bus.retire_valid = 1'b0;
    #1;
  endtask

  task automatic retire_all();
    for (int i = 0; i < D; i++) if (m_occ[i]) retire_one(i);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_in = '0; bus.req_in_valid = 0; bus.alloc_ready = 1;
    bus.retire_valid = 0; bus.retire_idx = '0;
    repeat (3) tick();
    reset = 1;
    tick();

    // reset state
    chk("rst_count", bus.pocq_count, 0);
    chk("rst_alloc_valid", bus.alloc_valid, 0);
    chk("rst_retire_err", bus.retire_err, 0);
    chk("rst_full", bus.pocq_full, 0);

    // single request
    pq.push_back(mk(48'h1000)); drive_head(); #1;
    chk("single_ready", bus.req_in_ready, 1);
    tick();
    chk("single_valid", bus.alloc_valid, 1);
    chk("single_idx", bus.alloc_idx, 0);
    chk("single_count", bus.pocq_count, 1);
    retire_one(0);
    chk("single_retired", bus.pocq_count, 0);

    // fill, then 17th held until a retire
    for (int i = 0; i <= D; i++) pq.push_back(mk(48'(i * 64)));
    drive_head(); #1;
    for (int i = 0; i < D; i++) begin
      tick();
      chk("fill_idx", bus.alloc_idx, i);
    end
    chk("fill_full", bus.pocq_full, 1);
    chk("fill_block", bus.req_in_ready, 0);
    tick(); tick();
    chk("fill_still_block", bus.req_in_ready, 0);
    retire_one(5);
    chk("fill_after_ret_cnt", bus.pocq_count, 15);
    chk("fill_after_ret_rdy", bus.req_in_ready, 1);
    tick();
    chk("fill_reuse_idx", bus.alloc_idx, 5);
    chk("fill_reuse_addr", bus.alloc_req.Addr, 48'h400);

    // simultaneous retire while full and head valid
    pq.push_back(mk(48'h2_0000)); drive_head(); #1;
    chk("simul_no_accept", bus.req_in_ready, 0);
    retire_one(3);
    chk("simul_count", bus.pocq_count, 15);
    chk("simul_ready", bus.req_in_ready, 1);
    tick();
    chk("simul_idx", bus.alloc_idx, 3);
    chk("simul_full", bus.pocq_count, 16);
    retire_all();
    chk("drain_count", bus.pocq_count, 0);

    // same-line hazard
    pq.push_back(mk(48'h2000)); pq.push_back(mk(48'h2010)); drive_head(); #1;
    tick();
    chk("haz_first_idx", bus.alloc_idx, 0);
`ifdef HNF_POCQ_HAZARD_EN
    chk("haz_block", bus.req_in_ready, 0);
    chk("haz_stall", bus.hazard_stall, 1);
    tick();
    chk("haz_still_block", bus.req_in_ready, 0);
    retire_one(0);
    chk("haz_unblock", bus.req_in_ready, 1);
    tick();
    chk("haz_idx", bus.alloc_idx, 0);
    chk("haz_addr", bus.alloc_req.Addr, 48'h2010);
`else
    chk("nohaz_ready", bus.req_in_ready, 1);
    tick();
    chk("nohaz_idx", bus.alloc_idx, 1);
`endif
    retire_all();

    // backpressure
    bus.alloc_ready = 0;
    pq.push_back(mk(48'h3000)); pq.push_back(mk(48'h3040)); drive_head(); #1;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("bp_valid", bus.alloc_valid, 1);
      chk("bp_idx", bus.alloc_idx, 0);
      chk("bp_addr", bus.alloc_req.Addr, 48'h3000);
      chk("bp_block", bus.req_in_ready, 0);
      tick();
    end
    bus.alloc_ready = 1; #1;
    chk("bp_release", bus.req_in_ready, 1);
    tick();
    chk("bp_idx2", bus.alloc_idx, 1);
    chk("bp_addr2", bus.alloc_req.Addr, 48'h3040);
    retire_all();

    // retire error and reset mid-HOLD
    retire_one(7);
    chk("err_set", bus.retire_err, 1);
    tick(); tick();
    chk("err_sticky", bus.retire_err, 1);
    bus.alloc_ready = 0;
    pq.push_back(mk(48'h4000)); drive_head(); #1;
    tick();
    chk("hold_valid", bus.alloc_valid, 1);
    reset = 0; #1;
    chk("rst_ready_low", bus.req_in_ready, 0);
    tick();
    chk("rst_mid_valid", bus.alloc_valid, 0);
    chk("rst_mid_count", bus.pocq_count, 0);
    chk("rst_mid_err", bus.retire_err, 0);
    reset = 1; bus.alloc_ready = 1;
    tick(); tick();
    retire_all();

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if (pq.size() < 4 && $urandom_range(0, 99) < 60) begin
        logic [47:0] a;
        a = 48'($urandom_range(0, 23)) * 48'd64 + 48'($urandom_range(0, 63));
        a[47:44] = 4'($urandom_range(0, 1));
        pq.push_back(mk(a));
      end
      bus.alloc_ready = ($urandom_range(0, 99) < 70);
      bus.retire_valid = 0;
      if ($urandom_range(0, 99) < 35) begin
        int s, pick;
        s = $urandom_range(0, D - 1);
        pick = $urandom_range(0, D - 1);
        if ($urandom_range(0, 99) < 90)
          for (int j = D - 1; j >= 0; j--) if (m_occ[(s + j) % D]) pick = (s + j) % D;
        bus.retire_valid = 1;
        bus.retire_idx = 4'(pick);
      end
      reset = !($urandom_range(0, 999) < 3);
      drive_head();
      tick();
    end
    reset = 1; bus.retire_valid = 0; bus.alloc_ready = 1;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
